// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends the 0x42 read command, releases DIO and shifts in
// four key bytes, then publishes the raw bytes together with a decoded 8-key vector.

module tm1638_key_reader #(
    parameter int CLK_DIV = 50,
    parameter int T_WAIT  = 200,
    parameter int T_HOLD  = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_start,
    input  logic        dio_in,
    output logic        sclk,
    output logic        stb,
    output logic        dio_out,
    output logic        dio_oe,
    output logic        busy,
    output logic [7:0]  keys,
    output logic [31:0] raw,
    output logic        keys_valid
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        TURN,
        READ,
        HOLD,
        DONE
    } state_t;

    localparam int MAX_SLOT_WAIT = (2 * CLK_DIV > T_WAIT) ? 2 * CLK_DIV : T_WAIT;
    localparam int CNT_MAX       = (MAX_SLOT_WAIT > T_HOLD) ? MAX_SLOT_WAIT : T_HOLD;
    localparam int CNT_W         = $clog2(CNT_MAX);

    localparam logic [7:0]       SCAN_CMD   = 8'h42;
    localparam logic [CNT_W-1:0] HALF_CNT   = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(T_WAIT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      raw_q, raw_d;
    logic [7:0]       keys_q, keys_d;
    logic             sclk_q, sclk_d;
    logic             stb_q, stb_d;
    logic             dio_out_q, dio_out_d;
    logic             dio_oe_q, dio_oe_d;
    logic             busy_q, busy_d;
    logic             keys_valid_q, keys_valid_d;
    logic             dio_meta_q, dio_meta_d;
    logic             dio_sync_q, dio_sync_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shadow_q     <= '0;
            raw_q        <= '0;
            keys_q       <= '0;
            sclk_q       <= 1'b1;
            stb_q        <= 1'b1;
            dio_out_q    <= 1'b1;
            dio_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            dio_meta_q   <= 1'b1;
            dio_sync_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shadow_q     <= shadow_d;
            raw_q        <= raw_d;
            keys_q       <= keys_d;
            sclk_q       <= sclk_d;
            stb_q        <= stb_d;
            dio_out_q    <= dio_out_d;
            dio_oe_q     <= dio_oe_d;
            busy_q       <= busy_d;
            keys_valid_q <= keys_valid_d;
            dio_meta_q   <= dio_meta_d;
            dio_sync_q   <= dio_sync_d;
        end
    end

    // Bus outputs are registered from the next state so they change cleanly on clock edges.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shadow_d   = shadow_q;
        raw_d      = raw_q;
        keys_d     = keys_q;
        dio_out_d  = dio_out_q;
        dio_meta_d = dio_in;
        dio_sync_d = dio_meta_q;

        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d   = SETUP;
                    cnt_d     = '0;
                    shadow_d  = '0;
                    dio_out_d = SCAN_CMD[0];
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CMD: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd7) begin
                        state_d = TURN;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TURN: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = READ;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            READ: begin
                if (cnt_q == HALF_CNT) begin
                    shadow_d[bit_q] = dio_sync_q;
                end
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd31) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    raw_d   = shadow_q;
                    for (int k = 0; k < 4; k++) begin
                        keys_d[k]     = shadow_q[8*k];
                        keys_d[k + 4] = shadow_q[8*k + 4];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new command bit is presented only as SCLK falls at the start of its slot.
        if (state_d == CMD && cnt_d == '0) begin
            dio_out_d = SCAN_CMD[bit_d[2:0]];
        end
        if (state_d == DONE || state_d == IDLE) begin
            dio_out_d = 1'b1;
        end

        sclk_d       = !((state_d == CMD || state_d == READ) && cnt_d < HALF_CNT);
        stb_d        = (state_d == IDLE) || (state_d == DONE);
        dio_oe_d     = (state_d == SETUP) || (state_d == CMD);
        busy_d       = (state_d != IDLE);
        keys_valid_d = (state_d == DONE);
    end

    assign sclk       = sclk_q;
    assign stb        = stb_q;
    assign dio_out    = dio_out_q;
    assign dio_oe     = dio_oe_q;
    assign busy       = busy_q;
    assign keys       = keys_q;
    assign raw        = raw_q;
    assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: a TM1638 key-data model answers the read command and
// every scan is scored against keys/raw/latency derived from the byte values.

module tb_tm1638_key_reader;

    localparam int CLK_DIV = 50;
    localparam int T_WAIT  = 200;
    localparam int T_HOLD  = 50;
    localparam int LATENCY = 1 + CLK_DIV + 16 * CLK_DIV + T_WAIT + 64 * CLK_DIV + T_HOLD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scan_start = 1'b0;
    logic        dio_in = 1'b1;
    logic        sclk, stb, dio_out, dio_oe, busy, keys_valid;
    logic [7:0]  keys;
    logic [31:0] raw;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor / device-model state, written only by the monitor process
    int         cyc = 0;
    logic       prev_sclk = 1'b1, prev_oe = 1'b0, prev_stb = 1'b1, prev_busy = 1'b0, prev_dout = 1'b1;
    int         read_idx = 0;
    int         cmd_rises = 0;
    logic [7:0] cmd_byte = 8'h00;
    int         rises_at_oe_fall = -1;
    int         oe_fall_cyc = 0;
    int         turn_len = -1;
    int         stb_high_run = 0;
    int         last_gap = 0;
    int         viol = 0;
    int         kv_cyc[$];
    int         accept_cyc[$];

    logic [7:0] dev_bytes [4];

    tm1638_key_reader #(
        .CLK_DIV(CLK_DIV),
        .T_WAIT (T_WAIT),
        .T_HOLD (T_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_start(scan_start),
        .dio_in    (dio_in),
        .sclk      (sclk),
        .stb       (stb),
        .dio_out   (dio_out),
        .dio_oe    (dio_oe),
        .busy      (busy),
        .keys      (keys),
        .raw       (raw),
        .keys_valid(keys_valid)
    );

    always #5 clk = ~clk;

    // Bus observer plus TM1638 key-data model; presents one bit per read slot on SCLK falls
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (busy && !prev_busy) accept_cyc.push_back(cyc - 1);
            if (keys_valid) kv_cyc.push_back(cyc);
            if (!stb && prev_stb) begin
                read_idx  = 0;
                cmd_rises = 0;
                cmd_byte  = 8'h00;
                turn_len  = -1;
                last_gap  = stb_high_run;
            end
            stb_high_run = stb ? stb_high_run + 1 : 0;
            if (sclk && !prev_sclk && dio_oe && !stb) begin
                if (cmd_rises < 8) cmd_byte[cmd_rises] = dio_out;
                cmd_rises++;
            end
            if (!dio_oe && prev_oe) begin
                rises_at_oe_fall = cmd_rises;
                oe_fall_cyc      = cyc;
            end
            if (!sclk && prev_sclk && !dio_oe && !stb) begin
                if (read_idx == 0) turn_len = cyc - oe_fall_cyc;
                if (read_idx < 32) dio_in = dev_bytes[read_idx / 8][read_idx % 8];
                read_idx++;
            end
            if (stb && (!sclk || dio_oe)) viol++;
            if (keys_valid && !stb) viol++;
            if (dio_oe && !busy) viol++;
            if (dio_oe && prev_oe && (dio_out != prev_dout) && !(!sclk && prev_sclk)) viol++;
        end
        prev_sclk = sclk;
        prev_oe   = dio_oe;
        prev_stb  = stb;
        prev_busy = busy;
        prev_dout = dio_out;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_sclk"}, 32'(sclk), 32'd1);
        check_output({tag, "_stb"}, 32'(stb), 32'd1);
        check_output({tag, "_dio_oe"}, 32'(dio_oe), 32'd0);
        check_output({tag, "_dio_out"}, 32'(dio_out), 32'd1);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_keys"}, 32'(keys), 32'd0);
        check_output({tag, "_raw"}, raw, 32'd0);
        check_output({tag, "_keys_valid"}, 32'(keys_valid), 32'd0);
    endtask

    // Key i is bit 0 (i<4) or bit 4 (i>=4) of key byte i%4
    function automatic logic [7:0] model_keys(input logic [7:0] b0, b1, b2, b3);
        logic [7:0] bytes [4];
        logic [7:0] k;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        k = 8'h00;
        for (int i = 0; i < 8; i++) k[i] = bytes[i % 4][(i < 4) ? 0 : 4];
        return k;
    endfunction

    task automatic apply_stimulus(input logic [7:0] b0, b1, b2, b3);
        dev_bytes[0] = b0; dev_bytes[1] = b1; dev_bytes[2] = b2; dev_bytes[3] = b3;
    endtask

    task automatic run_scan(input string tag, input logic [7:0] b0, b1, b2, b3);
        int  kv_base, acc_base, v_base, lat;
        bit  seen;
        kv_base  = kv_cyc.size();
        acc_base = accept_cyc.size();
        v_base   = viol;
        apply_stimulus(b0, b1, b2, b3);
        step();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LATENCY + 50 && !seen; i++) begin
            step();
            if (kv_cyc.size() > kv_base) seen = 1'b1;
        end
        check_output({tag, "_kv_seen"}, 32'(seen), 32'd1);
        check_output({tag, "_raw"}, raw, {b3, b2, b1, b0});
        check_output({tag, "_keys"}, 32'(keys), 32'(model_keys(b0, b1, b2, b3)));
        lat = (seen && accept_cyc.size() > acc_base) ? kv_cyc[kv_base] - accept_cyc[acc_base] : -1;
        check_output({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        check_output({tag, "_cmd_byte"}, 32'(cmd_byte), 32'h42);
        check_output({tag, "_oe_fall_after_rise"}, 32'(rises_at_oe_fall), 32'd8);
        check_output({tag, "_turn_len"}, 32'(turn_len), 32'(T_WAIT));
        check_output({tag, "_read_slots"}, 32'(read_idx), 32'd32);
        step();
        check_output({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_output({tag, "_kv_pulse"}, 32'(keys_valid), 32'd0);
        repeat (10) step();
        check_output({tag, "_kv_count"}, 32'(kv_cyc.size() - kv_base), 32'd1);
        check_output({tag, "_bus_rules"}, 32'(viol - v_base), 32'd0);
    endtask

    initial begin
        int         active;
        int         kv_base, acc_base;
        bit         hit;
        logic [7:0] r0, r1, r2, r3;

        $display("[TB] tm1638_key_reader bench, expected latency %0d cycles", LATENCY);

        // Reset held: a scan request must produce no bus activity
        active = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 5) scan_start = 1'b1;
            if (i == 6) scan_start = 1'b0;
            if (!sclk || !stb || dio_oe || !dio_out || busy || keys_valid || keys != 8'h00 || raw != 32'h0)
                active++;
        end
        check_output("reset_activity", 32'(active), 32'd0);
        check_reset_values("reset");
        rst = 1'b1;
        repeat (5) step();
        check_output("post_reset_idle_busy", 32'(busy), 32'd0);
        check_output("post_reset_idle_stb", 32'(stb), 32'd1);

        run_scan("fixed", 8'h01, 8'h10, 8'h00, 8'h11);
        check_output("fixed_raw_literal", raw, 32'h1100_1001);
        run_scan("released", 8'h00, 8'h00, 8'h00, 8'h00);

        for (int n = 0; n < 2; n++) begin
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
            run_scan($sformatf("rand%0d", n), r0, r1, r2, r3);
        end

        // Back-to-back: scan_start held high across two complete scans
        r0 = 8'($urandom) | 8'h01; r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
        apply_stimulus(r0, r1, r2, r3);
        kv_base  = kv_cyc.size();
        acc_base = accept_cyc.size();
        scan_start = 1'b1;
        for (int i = 0; i < 2 * LATENCY + 100 && kv_cyc.size() < kv_base + 2; i++) step();
        scan_start = 1'b0;
        check_output("b2b_kv_count", 32'(kv_cyc.size() - kv_base), 32'd2);
        check_output("b2b_accept_count", 32'(accept_cyc.size() - acc_base), 32'd2);
        if (kv_cyc.size() >= kv_base + 2 && accept_cyc.size() >= acc_base + 2) begin
            check_output("b2b_lat1", 32'(kv_cyc[kv_base] - accept_cyc[acc_base]), 32'(LATENCY));
            check_output("b2b_reaccept", 32'(accept_cyc[acc_base + 1] - kv_cyc[kv_base]), 32'd1);
            check_output("b2b_lat2", 32'(kv_cyc[kv_base + 1] - accept_cyc[acc_base + 1]), 32'(LATENCY));
        end
        check_output("b2b_stb_gap", 32'(last_gap >= 1), 32'd1);
        check_output("b2b_raw", raw, {r3, r2, r1, r0});
        check_output("b2b_keys", 32'(keys), 32'(model_keys(r0, r1, r2, r3)));
        repeat (20) step();
        check_output("b2b_no_extra_kv", 32'(kv_cyc.size() - kv_base), 32'd2);
        check_output("b2b_no_extra_accept", 32'(accept_cyc.size() - acc_base), 32'd2);

        // Reset in the middle of read slot 17
        apply_stimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        step();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < LATENCY && !hit; i++) begin
            step();
            if (read_idx == 18) hit = 1'b1;
        end
        check_output("midop_reached_bit17", 32'(hit), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_values("midop");
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
        run_scan("after_reset", r0, r1, r2, r3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
